microcode_sequencer: RTL and testbench



---
 rtl/microcode_sequencer_if.sv | 30 +++
 rtl/microcode_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_microcode_sequencer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/microcode_sequencer_if.sv
// Sequencer <-> datapath/ROM bundle: decode fields and memory handshake in,
// RT codes, status pulses and counters out.
interface microcode_sequencer_if #(
    parameter int INST_CNT_W = 16,
    parameter int CYC_CNT_W  = 32
);
    logic [3:0]            opcode;
    logic [5:0]            funct;
    logic                  mem_ready;
    logic [3:0]            rt_one;
    logic [3:0]            rt_two;
    logic [3:0]            state;
    logic                  inst_done;
    logic                  output_port_en;
    logic                  is_halted;
    logic [INST_CNT_W-1:0] num_inst;
    logic [CYC_CNT_W-1:0]  num_cycle;

    modport master (
        input  opcode, funct, mem_ready,
        output rt_one, rt_two, state, inst_done, output_port_en,
        is_halted, num_inst, num_cycle
    );

    modport slave (
        output opcode, funct, mem_ready,
        input  rt_one, rt_two, state, inst_done, output_port_en,
        is_halted, num_inst, num_cycle
    );
endinterface

// File: rtl/microcode_sequencer.sv
// Multi-cycle control sequencer for the 16-bit TSC CPU: steps a per-instruction FSM
// and emits two RT codes per cycle. Define PERF_COUNT_EN to build the cycle counter.
module microcode_sequencer #(
    parameter int INST_CNT_W = 16,
    parameter int CYC_CNT_W  = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    microcode_sequencer_if.master  bus
);
    localparam logic [3:0] RT_IR_FETCH = 4'd0;
    localparam logic [3:0] RT_PC_INC   = 4'd1;
    localparam logic [3:0] RT_PC_IMM   = 4'd2;
    localparam logic [3:0] RT_JUMP     = 4'd3;
    localparam logic [3:0] RT_LINK     = 4'd4;
    localparam logic [3:0] RT_PC_REG   = 4'd5;
    localparam logic [3:0] RT_ALU_IMM  = 4'd6;
    localparam logic [3:0] RT_ALU_REG  = 4'd7;
    localparam logic [3:0] RT_BRANCH   = 4'd8;
    localparam logic [3:0] RT_WB_RT    = 4'd9;
    localparam logic [3:0] RT_WB_RD    = 4'd10;
    localparam logic [3:0] RT_MEM_RD   = 4'd11;
    localparam logic [3:0] RT_MEM_WR   = 4'd12;
    localparam logic [3:0] RT_WB_MDR   = 4'd13;
    localparam logic [3:0] RT_NOP      = 4'd14;

    // Bit 4 only separates WWD/JRL_EX from the 4-bit code they share on the state port.
    typedef enum logic [4:0] {
        S_IDLE    = 5'd0,
        S_FETCH   = 5'd1,
        S_DECODE  = 5'd2,
        S_R_EX    = 5'd3,
        S_R_WB    = 5'd4,
        S_I_EX    = 5'd5,
        S_I_WB    = 5'd6,
        S_ADDR_EX = 5'd7,
        S_LD_MEM  = 5'd8,
        S_LD_WB   = 5'd9,
        S_ST_MEM  = 5'd10,
        S_BR_EX   = 5'd11,
        S_JMP_EX  = 5'd12,
        S_JAL_EX  = 5'd13,
        S_JPR_EX  = 5'd14,
        S_HALT    = 5'd15,
        S_JRL_EX  = 5'd30,
        S_WWD     = 5'd31
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_halted;
    logic [INST_CNT_W-1:0] r_num_inst;
    logic [3:0]            w_rt_one;
    logic [3:0]            w_rt_two;
    logic                  w_inst_done;
    logic                  w_port_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_halted   <= 1'b0;
            r_num_inst <= '0;
        end else begin
            r_state  <= w_next;
            r_halted <= r_halted | (r_state == S_HALT);
            if (w_inst_done)
                r_num_inst <= r_num_inst + INST_CNT_W'(1);
        end
    end

    always_comb begin
        w_next      = r_state;
        w_rt_one    = RT_NOP;
        w_rt_two    = RT_NOP;
        w_inst_done = 1'b0;
        w_port_en   = 1'b0;
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                w_rt_one = RT_IR_FETCH;
                // PC only advances on the cycle the fetch actually lands.
                if (bus.mem_ready) begin
                    w_rt_two = RT_PC_INC;
                    w_next   = S_DECODE;
                end
            end
            S_DECODE: begin
                w_rt_one = RT_PC_IMM;
                case (bus.opcode)
                    4'd0, 4'd1, 4'd2, 4'd3: w_next = S_BR_EX;
                    4'd4, 4'd5, 4'd6:       w_next = S_I_EX;
                    4'd7, 4'd8:             w_next = S_ADDR_EX;
                    4'd9:                   w_next = S_JMP_EX;
                    4'd10:                  w_next = S_JAL_EX;
                    4'd15: begin
                        case (bus.funct)
                            6'd25:   w_next = S_JPR_EX;
                            6'd26:   w_next = S_JRL_EX;
                            6'd28:   w_next = S_WWD;
                            6'd29:   w_next = S_HALT;
                            default: w_next = S_R_EX;
                        endcase
                    end
                    default:                w_next = S_FETCH;
                endcase
            end
            S_R_EX: begin
                w_rt_one = RT_ALU_REG;
                w_next   = S_R_WB;
            end
            S_R_WB: begin
                w_rt_one    = RT_WB_RD;
                w_inst_done = 1'b1;
                w_next      = S_FETCH;
            end
            S_I_EX: begin
                w_rt_one = RT_ALU_IMM;
                w_next   = S_I_WB;
            end
            S_I_WB: begin
                w_rt_one    = RT_WB_RT;
                w_inst_done = 1'b1;
                w_next      = S_FETCH;
            end
            S_ADDR_EX: begin
                w_rt_one = RT_ALU_IMM;
                w_next   = (bus.opcode == 4'd7) ? S_LD_MEM : S_ST_MEM;
            end
            S_LD_MEM: begin
                w_rt_one = RT_MEM_RD;
                if (bus.mem_ready)
                    w_next = S_LD_WB;
            end
            S_LD_WB: begin
                w_rt_one    = RT_WB_MDR;
                w_inst_done = 1'b1;
                w_next      = S_FETCH;
            end
            S_ST_MEM: begin
                w_rt_one = RT_MEM_WR;
                if (bus.mem_ready) begin
                    w_inst_done = 1'b1;
                    w_next      = S_FETCH;
                end
            end
            S_BR_EX: begin
                w_rt_one    = RT_BRANCH;
                w_inst_done = 1'b1;
                w_next      = S_FETCH;
            end
            S_JMP_EX: begin
                w_rt_one    = RT_JUMP;
                w_inst_done = 1'b1;
                w_next      = S_FETCH;
            end
            S_JAL_EX: begin
                w_rt_one    = RT_JUMP;
                w_rt_two    = RT_LINK;
                w_inst_done = 1'b1;
                w_next      = S_FETCH;
            end
            S_JPR_EX: begin
                w_rt_one    = RT_PC_REG;
                w_inst_done = 1'b1;
                w_next      = S_FETCH;
            end
            S_JRL_EX: begin
                w_rt_one    = RT_PC_REG;
                w_rt_two    = RT_LINK;
                w_inst_done = 1'b1;
                w_next      = S_FETCH;
            end
            S_WWD: begin
                w_rt_one    = RT_ALU_REG;
                w_port_en   = 1'b1;
                w_inst_done = 1'b1;
                w_next      = S_FETCH;
            end
            S_HALT: begin
                // Only the entry cycle retires HLT; afterwards the FSM just idles here.
                w_inst_done = ~r_halted;
                w_next      = S_HALT;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign bus.rt_one         = w_rt_one;
    assign bus.rt_two         = w_rt_two;
    assign bus.state          = r_state[3:0];
    assign bus.inst_done      = w_inst_done;
    assign bus.output_port_en = w_port_en;
    assign bus.is_halted      = r_halted;
    assign bus.num_inst       = r_num_inst;

`ifdef PERF_COUNT_EN
    logic [CYC_CNT_W-1:0] r_num_cycle;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_num_cycle <= '0;
        else if (r_state != S_IDLE && !r_halted && r_num_cycle != '1)
            r_num_cycle <= r_num_cycle + CYC_CNT_W'(1);
    end

    assign bus.num_cycle = r_num_cycle;
`else
    assign bus.num_cycle = '0;
`endif
endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed bench for microcode_sequencer: per-cycle expectations are queued by the
// stimulus thread and popped/compared by a negedge monitor.
module tb_microcode_sequencer;
    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_errors = 0;

    typedef struct {
        int st;     // -1: state code not compared
        int r1;
        int r2;
        int done;
        int oen;
        int hlt;
        int ni;
    } exp_t;

    exp_t sb[$];

    microcode_sequencer_if #(.INST_CNT_W(16), .CYC_CNT_W(32)) bus ();

    microcode_sequencer #(.INST_CNT_W(16), .CYC_CNT_W(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            if (e.st >= 0) chk("state", 32'(bus.state), e.st);
            chk("rt_one", 32'(bus.rt_one), e.r1);
            chk("rt_two", 32'(bus.rt_two), e.r2);
            chk("inst_done", 32'(bus.inst_done), e.done);
            chk("output_port_en", 32'(bus.output_port_en), e.oen);
            chk("is_halted", 32'(bus.is_halted), e.hlt);
            chk("num_inst", 32'(bus.num_inst), e.ni);
        end
    end

    // Advance one clock, drive this cycle's inputs, queue what the DUT must show.
    task automatic step(input logic mr, input logic [3:0] op, input logic [5:0] fn,
                        input int st, input int r1, input int r2, input int done,
                        input int oen, input int hlt, input int ni);
        exp_t e;
        @(posedge clk);
        #1;
        bus.mem_ready = mr;
        bus.opcode    = op;
        bus.funct     = fn;
        e = '{st, r1, r2, done, oen, hlt, ni};
        sb.push_back(e);
    endtask

    task automatic async_reset_checks(input string tag);
        #1;
        chk({tag, " state"},     32'(bus.state), 0);
        chk({tag, " num_inst"},  32'(bus.num_inst), 0);
        chk({tag, " is_halted"}, 32'(bus.is_halted), 0);
        chk({tag, " rt_one"},    32'(bus.rt_one), 14);
        chk({tag, " rt_two"},    32'(bus.rt_two), 14);
        chk({tag, " inst_done"}, 32'(bus.inst_done), 0);
        chk({tag, " num_cycle"}, bus.num_cycle, 0);
    endtask

    initial begin
        int budget;
        exp_t e;
        reset_n       = 1'b0;
        bus.mem_ready = 1'b1;
        bus.opcode    = 4'd15;
        bus.funct     = 6'd0;

        @(posedge clk);
        #1;
        e = '{0, 14, 14, 0, 0, 0, 0};
        sb.push_back(e);
        @(negedge clk);
        #1;
        chk("reset num_cycle", bus.num_cycle, 0);
        reset_n = 1'b1;

        // ADD
        step(1, 15, 0,  1,  0,  1, 0, 0, 0, 0);
        step(1, 15, 0,  2,  2, 14, 0, 0, 0, 0);
        step(1, 15, 0,  3,  7, 14, 0, 0, 0, 0);
        step(1, 15, 0,  4, 10, 14, 1, 0, 0, 0);
        // LWD, LD_MEM waits two cycles
        step(1, 7, 0,  1,  0,  1, 0, 0, 0, 1);
        step(0, 7, 0,  2,  2, 14, 0, 0, 0, 1);
        step(0, 7, 0,  7,  6, 14, 0, 0, 0, 1);
        step(0, 7, 0,  8, 11, 14, 0, 0, 0, 1);
        step(0, 7, 0,  8, 11, 14, 0, 0, 0, 1);
        step(1, 7, 0,  8, 11, 14, 0, 0, 0, 1);
        step(0, 7, 0,  9, 13, 14, 1, 0, 0, 1);
        // ADDI, fetch stalls three cycles
        step(0, 4, 0,  1,  0, 14, 0, 0, 0, 2);
        step(0, 4, 0,  1,  0, 14, 0, 0, 0, 2);
        step(0, 4, 0,  1,  0, 14, 0, 0, 0, 2);
        step(1, 4, 0,  1,  0,  1, 0, 0, 0, 2);
        step(1, 4, 0,  2,  2, 14, 0, 0, 0, 2);
        step(1, 4, 0,  5,  6, 14, 0, 0, 0, 2);
        step(1, 4, 0,  6,  9, 14, 1, 0, 0, 2);
        // SWD, one wait cycle in ST_MEM
        step(1, 8, 0,  1,  0,  1, 0, 0, 0, 3);
        step(1, 8, 0,  2,  2, 14, 0, 0, 0, 3);
        step(1, 8, 0,  7,  6, 14, 0, 0, 0, 3);
        step(0, 8, 0, 10, 12, 14, 0, 0, 0, 3);
        step(1, 8, 0, 10, 12, 14, 1, 0, 0, 3);
        // branch
        step(1, 0, 0,  1,  0,  1, 0, 0, 0, 4);
        step(1, 0, 0,  2,  2, 14, 0, 0, 0, 4);
        step(1, 0, 0, 11,  8, 14, 1, 0, 0, 4);
        // unused opcode: back to FETCH, not counted
        step(1, 11, 0, 1,  0,  1, 0, 0, 0, 5);
        step(1, 11, 0, 2,  2, 14, 0, 0, 0, 5);
        // JAL
        step(1, 10, 0, 1,  0,  1, 0, 0, 0, 5);
        step(1, 10, 0, 2,  2, 14, 0, 0, 0, 5);
        step(1, 10, 0, 13, 3,  4, 1, 0, 0, 5);
        // JRL
        step(1, 15, 26, 1, 0,  1, 0, 0, 0, 6);
        step(1, 15, 26, 2, 2, 14, 0, 0, 0, 6);
        step(1, 15, 26, 14, 5, 4, 1, 0, 0, 6);
        // JPR
        step(1, 15, 25, 1, 0,  1, 0, 0, 0, 7);
        step(1, 15, 25, 2, 2, 14, 0, 0, 0, 7);
        step(1, 15, 25, 14, 5, 14, 1, 0, 0, 7);
        // JMP
        step(1, 9, 0,  1,  0,  1, 0, 0, 0, 8);
        step(1, 9, 0,  2,  2, 14, 0, 0, 0, 8);
        step(1, 9, 0, 12,  3, 14, 1, 0, 0, 8);
        // WWD
        step(1, 15, 28, 1, 0,  1, 0, 0, 0, 9);
        step(1, 15, 28, 2, 2, 14, 0, 0, 0, 9);
        step(1, 15, 28, -1, 7, 14, 1, 1, 0, 9);
        // HLT, then stays halted
        step(1, 15, 29, 1, 0,  1, 0, 0, 0, 10);
        step(1, 15, 29, 2, 2, 14, 0, 0, 0, 10);
        step(1, 15, 29, -1, 14, 14, 1, 0, 0, 10);
        step(1, 15, 0, -1, 14, 14, 0, 0, 1, 11);
        step(1, 15, 0, -1, 14, 14, 0, 0, 1, 11);
        step(1, 15, 0, -1, 14, 14, 0, 0, 1, 11);

        @(negedge clk);
        #1;
        reset_n = 1'b0;
        async_reset_checks("halt reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // ADD then LWD abandoned in LD_MEM
        step(1, 15, 0,  1,  0,  1, 0, 0, 0, 0);
        step(1, 15, 0,  2,  2, 14, 0, 0, 0, 0);
        step(1, 15, 0,  3,  7, 14, 0, 0, 0, 0);
        step(1, 15, 0,  4, 10, 14, 1, 0, 0, 0);
        step(1, 7, 0,  1,  0,  1, 0, 0, 0, 1);
        step(1, 7, 0,  2,  2, 14, 0, 0, 0, 1);
        step(1, 7, 0,  7,  6, 14, 0, 0, 0, 1);
        step(0, 7, 0,  8, 11, 14, 0, 0, 0, 1);
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        async_reset_checks("ld_mem reset");
        #10;
        reset_n = 1'b1;

        budget = 20;
        while (sb.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (sb.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
